// File: rtl/segment_accumulator.sv
// Segment accumulator: sums LEN-element segments delimited by ilast, one result per segment.
// Optional macro SEGMENT_ACCUMULATOR_LEN_CHECK_EN enables the per-segment length check driving err.
module segment_accumulator #(
    parameter int LEN    = 8,
    parameter int W      = 8,
    parameter int SIGNED = 0,
    localparam int WA    = W + $clog2(LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  idat,
    input  logic          ilast,
    input  logic          ifin,
    input  logic          ivld,
    output logic          irdy,
    output logic [WA-1:0] odat,
    output logic          olast,
    output logic          ovld,
    input  logic          ordy,
    output logic          err
);

    logic [WA-1:0] acc;
    logic [WA-1:0] ext_dat;
    logic [WA-1:0] sum;
    logic          first;
    logic          fire;
    logic          eff_last;

    assign irdy     = !rst && (!ovld || ordy);
    assign fire     = ivld && irdy;
    // With a single-element segment every beat closes its segment.
    assign eff_last = ilast || (LEN == 1);

    generate
        if (SIGNED != 0) begin : g_sext
            assign ext_dat = WA'($signed(idat));
        end else begin : g_zext
            assign ext_dat = WA'(idat);
        end
    endgenerate

    assign sum = first ? ext_dat : acc + ext_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            first <= 1'b1;
            odat  <= '0;
            olast <= 1'b0;
            ovld  <= 1'b0;
        end else begin
            if (ovld && ordy)
                ovld <= 1'b0;
            // A closing beat accepted while the old result drains reloads the output in place.
            if (fire) begin
                if (eff_last) begin
                    odat  <= sum;
                    olast <= ifin;
                    ovld  <= 1'b1;
                    first <= 1'b1;
                end else begin
                    acc   <= sum;
                    first <= 1'b0;
                end
            end
        end
    end

`ifdef SEGMENT_ACCUMULATOR_LEN_CHECK_EN
    localparam int            CW       = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

    logic [CW-1:0] cnt;
    logic          err_q;
    logic          bad;

    assign bad = (eff_last && (cnt != LAST_IDX)) ||
                 (!eff_last && (cnt == LAST_IDX)) ||
                 (ifin && !eff_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (fire) begin
            err_q <= err_q | bad;
            // Saturate on overlong segments so the error keeps firing instead of wrapping.
            if (eff_last)
                cnt <= '0;
            else if (cnt != LAST_IDX)
                cnt <= cnt + 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_segment_accumulator.sv
// Bench for segment_accumulator: vector table, directed corner sequences and a randomized
// stream checked against a queue-based reference model of segment sums.
module tb_segment_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  idat;
    logic        ilast, ifin, ivld, ordy;

    logic        irdy7, olast7, ovld7, err7;
    logic [10:0] odat7;
    logic        irdy8, olast8, ovld8, err8;
    logic [10:0] odat8;
    logic        irdy10s, olast10s, ovld10s, err10s;
    logic [11:0] odat10s;
    logic        irdy10u, olast10u, ovld10u, err10u;
    logic [11:0] odat10u;

    always #5 clk = ~clk;

    segment_accumulator #(.LEN(7), .W(8), .SIGNED(0)) u_d7 (
        .clk(clk), .rst(rst), .idat(idat), .ilast(ilast), .ifin(ifin), .ivld(ivld),
        .irdy(irdy7), .odat(odat7), .olast(olast7), .ovld(ovld7), .ordy(ordy), .err(err7));
    segment_accumulator #(.LEN(8), .W(8), .SIGNED(0)) u_d8 (
        .clk(clk), .rst(rst), .idat(idat), .ilast(ilast), .ifin(ifin), .ivld(ivld),
        .irdy(irdy8), .odat(odat8), .olast(olast8), .ovld(ovld8), .ordy(ordy), .err(err8));
    segment_accumulator #(.LEN(10), .W(8), .SIGNED(1)) u_d10s (
        .clk(clk), .rst(rst), .idat(idat), .ilast(ilast), .ifin(ifin), .ivld(ivld),
        .irdy(irdy10s), .odat(odat10s), .olast(olast10s), .ovld(ovld10s), .ordy(ordy), .err(err10s));
    segment_accumulator #(.LEN(10), .W(8), .SIGNED(0)) u_d10u (
        .clk(clk), .rst(rst), .idat(idat), .ilast(ilast), .ifin(ifin), .ivld(ivld),
        .irdy(irdy10u), .odat(odat10u), .olast(olast10u), .ovld(ovld10u), .ordy(ordy), .err(err10u));

    typedef struct { int sum; bit fin; } res_t;
    typedef struct { bit v; int d; bit l; bit f; bit eo; int ed; bit el; } vec_t;

    res_t q[$];
    int   msum = 0;
    int   n_pass = 0, n_tot = 0;
    int   n_push = 0, n_pop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock: check the LEN=7 instance against the model, then advance past the edge.
    task automatic step(output bit accepted);
        #1;
        chk("d7_irdy", irdy7, (rst || (ovld7 && !ordy)) ? 32'd0 : 32'd1);
        chk("d7_ovld", ovld7, q.size() > 0);
        if (ovld7 && q.size() > 0) begin
            chk("d7_odat", odat7, q[0].sum);
            chk("d7_olast", olast7, q[0].fin);
            if (ordy) begin
                void'(q.pop_front());
                n_pop++;
            end
        end
        accepted = ivld && irdy7;
        if (accepted) begin
            msum += idat;
            if (ilast) begin
                q.push_back('{msum % 2048, ifin});
                n_push++;
                msum = 0;
            end
        end
        if (rst) begin
            q.delete();
            msum = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d, input bit l, input bit f);
        bit a;
        ivld = 1'b1; idat = 8'(d); ilast = l; ifin = f;
        step(a);
        chk("beat_accept", a, 1);
    endtask

    task automatic idle(input int n);
        bit a;
        ivld = 1'b0; ilast = 1'b0; ifin = 1'b0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic do_rst();
        bit a;
        rst = 1'b1; ivld = 1'b0; ilast = 1'b0; ifin = 1'b0;
        step(a);
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        bit   a;
        int   segs, k, hold, nstall;
        bit   prev_ov;

        for (int i = 0; i < 7; i++)
            tbl[i] = '{1'b1, i, i == 6, i == 6, i == 6, (i == 6) ? 21 : 0, i == 6};
        tbl[7] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};

        rst = 1'b1; ivld = 1'b0; ordy = 1'b1; idat = '0; ilast = 1'b0; ifin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovld", ovld7, 0);
        chk("rst_odat", odat7, 0);
        chk("rst_olast", olast7, 0);
        chk("rst_err", err7, 0);
        chk("rst_irdy", irdy7, 0);
        chk("rst_ovld10", ovld10s, 0);
        rst = 1'b0;

        // 0..6 with ilast/ifin on 6: one result of 21, one cycle after the last beat
        for (int i = 0; i < 8; i++) begin
            ivld = tbl[i].v; idat = 8'(tbl[i].d); ilast = tbl[i].l; ifin = tbl[i].f;
            step(a);
            chk("tbl_ovld", ovld7, tbl[i].eo);
            if (tbl[i].eo) begin
                chk("tbl_odat", odat7, tbl[i].ed);
                chk("tbl_olast", olast7, tbl[i].el);
            end
        end

        // Reset mid-segment must discard the partial sum 0+1+2
        for (int i = 0; i < 3; i++) beat(i, 1'b0, 1'b0);
        do_rst();
        for (int i = 0; i < 7; i++) beat(i, i == 6, i == 6);
        chk("rst_mid_odat", odat7, 21);
        chk("rst_mid_ovld", ovld7, 1);
        idle(1);

        // LEN=8: ten back-to-back replays of 0..7, ifin only on the tenth
        do_rst();
        for (int r = 0; r < 10; r++)
            for (int v = 0; v < 8; v++) begin
                beat(v, v == 7, (r == 9) && (v == 7));
                chk("d8_irdy", irdy8, 1);
                if (v == 7) begin
                    chk("d8_ovld", ovld8, 1);
                    chk("d8_odat", odat8, 28);
                    chk("d8_olast", olast8, r == 9);
                end
            end
        idle(1);
        chk("d8_ovld_end", ovld8, 0);

        // LEN=10 extremes: signed -128 x10 and unsigned 255 x10
        do_rst();
        for (int i = 0; i < 10; i++) beat(8'h80, i == 9, 1'b0);
        chk("d10s_ovld", ovld10s, 1);
        chk("d10s_odat", odat10s, 12'hB00);
        for (int i = 0; i < 10; i++) beat(8'hFF, i == 9, 1'b0);
        chk("d10u_ovld", ovld10u, 1);
        chk("d10u_odat", odat10u, 2550);
        idle(1);

        // Short segment: ilast on the 5th beat of a LEN=7 segment
        do_rst();
        chk("err_after_rst", err7, 0);
        for (int i = 0; i < 4; i++) beat(i, 1'b0, 1'b0);
        chk("err_before_short", err7, 0);
        beat(4, 1'b1, 1'b0);
`ifdef SEGMENT_ACCUMULATOR_LEN_CHECK_EN
        chk("err_rise", err7, 1);
        idle(5);
        chk("err_sticky", err7, 1);
        do_rst();
        chk("err_cleared", err7, 0);
`else
        chk("err_tied", err7, 0);
        idle(5);
        chk("err_tied_late", err7, 0);
        do_rst();
`endif

        // Random valid gaps, random ordy, plus 20-cycle output stalls after some results
        n_push = 0; n_pop = 0; segs = 0; k = 0; hold = 0; nstall = 0; prev_ov = 1'b0;
        ivld = 1'b0;
        for (int c = 0; c < 4000 && segs < 40; c++) begin
            if (!prev_ov && ovld7 && nstall < 4) begin
                hold = 20;
                nstall++;
            end
            prev_ov = ovld7;
            if (hold > 0) begin
                ordy = 1'b0;
                hold--;
            end else begin
                ordy = ($urandom_range(0, 3) != 0);
            end
            if (!ivld && $urandom_range(0, 9) < 7) begin
                ivld  = 1'b1;
                idat  = 8'($urandom_range(0, 255));
                ilast = (k == 6);
                ifin  = ilast && ($urandom_range(0, 1) == 1);
            end
            step(a);
            if (a) begin
                ivld = 1'b0;
                if (k == 6) begin
                    k = 0;
                    segs++;
                end else begin
                    k++;
                end
            end
        end
        chk("rand_segs_done", segs, 40);
        ordy = 1'b1;
        idle(3);
        chk("rand_pushed", n_push, 40);
        chk("rand_no_loss", n_pop, n_push);
        chk("rand_stalls", nstall, 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/segment_accumulator.md
SEGMENT_ACCUMULATOR -- requirements
Module: segment_accumulator

Interface
REQ-001 SHALL provide parameter LEN, default 8, meaning elements per segment, where LEN >= 1.
REQ-002 SHALL provide parameter W, default 8, meaning input element width.
REQ-003 SHALL provide parameter SIGNED, default 0, meaning 1 = two's-complement elements with sign-extension, 0 = unsigned with zero-extension.
REQ-004 SHALL use derived width WA = W + $clog2(LEN) for the accumulator and result.
REQ-005 SHALL provide port clk, input, 1 bit: single clock; all logic uses the rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL provide port idat, input, W bits: element from the upstream replay stage.
REQ-008 SHALL provide port ilast, input, 1 bit: marks the final element of a segment.
REQ-009 SHALL provide port ifin, input, 1 bit: marks the final element of the final replay of a vector; valid only together with ilast.
REQ-010 SHALL provide ports ivld (input) and irdy (output), 1 bit each: input handshake.
REQ-011 SHALL provide port odat, output, WA bits: segment sum.
REQ-012 SHALL provide port olast, output, 1 bit: copy of ifin captured with the segment's final element.
REQ-013 SHALL provide ports ovld (output) and ordy (input), 1 bit each: output handshake.
REQ-014 SHALL provide port err, output, 1 bit: sticky framing-error flag.

Function
REQ-015 SHALL accept an input beat when ivld && irdy in the same cycle; idat/ilast/ifin are sampled only on accepted beats.
REQ-016 SHALL drive irdy = !ovld || ordy, combinationally, so a full segment stream passes at one element per cycle with no bubbles.
REQ-017 SHALL load the accumulator with ext(idat) on the first accepted beat of a segment and with acc + ext(idat) on later beats, arithmetic modulo 2^WA.
REQ-018 On an accepted beat with ilast=1, SHALL register odat = acc + ext(idat) (or ext(idat) when it is also the first beat), set olast = ifin and ovld = 1 on the next edge, and mark the next beat as first-of-segment; latency from ilast beat to ovld is 1 cycle.
REQ-019 SHALL hold odat, olast and ovld stable while ovld && !ordy.
REQ-020 SHALL clear ovld after a cycle with ovld && ordy, unless a new ilast beat is accepted in that same cycle, in which case the new result is loaded and ovld stays 1.
REQ-021 SHALL stall the input (irdy=0) only while ovld && !ordy; partial accumulation is held unchanged during a stall.
REQ-022 SHALL ignore ifin on beats without ilast (no effect on olast).
REQ-023 With LEN=1, SHALL treat every beat as both first and last of its segment.

Reset
REQ-024 With rst=1 at a rising edge, SHALL set ovld=0, olast=0, odat=0, err=0, accumulator=0, element counter=0 and first-of-segment=1.
REQ-025 While rst=1, SHALL drive irdy=0; a reset mid-segment discards the partial sum and any unconsumed result.

Configuration
REQ-026 With macro SEGMENT_ACCUMULATOR_LEN_CHECK_EN defined, SHALL count accepted beats per segment and set err sticky (until reset) when ilast arrives with a count other than LEN-1, when beat LEN-1 arrives without ilast, or when ifin=1 without ilast; the result is still produced from the beats received.
REQ-027 Without SEGMENT_ACCUMULATOR_LEN_CHECK_EN, SHALL omit the element counter, tie err to 0 and delimit segments solely by ilast.

Verification
REQ-028 LEN=7, W=8, SIGNED=0, ordy=1: stream 0..6 with ilast on 6, ifin=1 -> one result odat=21, olast=1, ovld exactly one cycle after the ilast beat.
REQ-029 LEN=8: same 8 values 0..7 replayed 10 times back-to-back, ifin on the 10th ilast -> 10 results of 28, olast=1 only on the 10th, irdy constantly 1.
REQ-030 LEN=10, SIGNED=1, W=8: all elements -128 -> odat=-1280 (WA=12) -> 0xB00; SIGNED=0 with all 255 -> 2550.
REQ-031 Random ivld gaps and ordy held 0 for 20 cycles after a result -> irdy=0 only while stalled, no sum corrupted, no result lost or duplicated.
REQ-032 With SEGMENT_ACCUMULATOR_LEN_CHECK_EN defined, LEN=7, ilast on the 5th beat -> err rises the next cycle and stays 1 until rst; without the macro err stays 0.
REQ-033 Assert rst in mid-segment after 3 beats of 0..2, then stream 0..6 -> first result 21, not 24.
